// File: rtl/global_buffer_responder_if.sv
// Scheduler and DMA request/response bundle for the global-buffer responder.
// master = requester side (scheduler + DMA engine), slave = the responder SRAM.
interface global_buffer_responder_if #(
  parameter int DATA_W = 16
);
  logic [31:0]       gb_addr;
  logic [DATA_W-1:0] gb_wdata;
  logic              gb_we;
  logic              gb_ce;
  logic [DATA_W-1:0] gb_rdata;

  logic [31:0]       dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_we;
  logic              dma_ce;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;
  logic              dma_busy;

  logic              oob_err;
  logic              parity_err;

  modport master (
    output gb_addr, gb_wdata, gb_we, gb_ce,
    output dma_addr, dma_wdata, dma_we, dma_ce,
    input  gb_rdata, dma_rdata, dma_done, dma_busy, oob_err, parity_err
  );

  modport slave (
    input  gb_addr, gb_wdata, gb_we, gb_ce,
    input  dma_addr, dma_wdata, dma_we, dma_ce,
    output gb_rdata, dma_rdata, dma_done, dma_busy, oob_err, parity_err
  );
endinterface

// File: rtl/global_buffer_responder.sv
// Single-port DEPTH x 16 global buffer shared by the scheduler (priority, latency 1) and a latched DMA port.
// Optional feature: define GLOBAL_BUFFER_PARITY_EN to store and check a parity bit per word.
module global_buffer_responder #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  global_buffer_responder_if.slave  bus
);

`ifdef GLOBAL_BUFFER_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {
    D_IDLE = 1'b0,
    D_PEND = 1'b1
  } dma_state_t;

  dma_state_t        state_q;
  dma_state_t        state_d;
  logic              dma_accept;
  logic              dma_go;
  logic              dma_busy_c;

  // Latched DMA request
  logic [31:0]       dma_addr_q;
  logic [DATA_W-1:0] dma_wdata_q;
  logic              dma_we_q;

  logic [MEM_W-1:0]  mem [DEPTH];

  // The one SRAM access of this cycle
  logic              acc_en;
  logic              acc_we;
  logic              acc_oob;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] gb_rdata_p1;
  logic [DATA_W-1:0] dma_rdata_p1;
  logic              dma_done_p1;
  logic              oob_err_q;

  // ---- stage 0: arbitration, scheduler always wins the single SRAM port
  always_comb begin
    acc_en    = bus.gb_ce | dma_go;
    acc_we    = bus.gb_ce ? bus.gb_we    : dma_we_q;
    acc_addr  = bus.gb_ce ? bus.gb_addr  : dma_addr_q;
    acc_wdata = bus.gb_ce ? bus.gb_wdata : dma_wdata_q;
  end

  assign acc_idx = acc_addr[ADDR_W-1:0];
  assign acc_oob = |(acc_addr >> ADDR_W);
  assign rd_word = mem[acc_idx];
  assign rd_data = acc_oob ? '0 : rd_word[DATA_W-1:0];

`ifdef GLOBAL_BUFFER_PARITY_EN
  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  logic parity_err_q;

  assign wr_word = {parity_of(acc_wdata), acc_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (acc_en && !acc_we && !acc_oob &&
                 (parity_of(rd_word[DATA_W-1:0]) != rd_word[DATA_W])) begin
      parity_err_q <= 1'b1;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign wr_word        = acc_wdata;
  assign bus.parity_err = 1'b0;
`endif

  // ---- stage 1: SRAM write and registered responses
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && !acc_oob) begin
      mem[acc_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gb_rdata_p1  <= '0;
      dma_rdata_p1 <= '0;
      dma_done_p1  <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      dma_done_p1 <= dma_go;
      if (bus.gb_ce && !bus.gb_we) begin
        gb_rdata_p1 <= rd_data;
      end
      if (dma_go && !dma_we_q) begin
        dma_rdata_p1 <= rd_data;
      end
      if (acc_en && acc_oob) begin
        oob_err_q <= 1'b1;
      end
    end
  end

  // DMA request holding registers carry data only, so they need no reset
  always_ff @(posedge clk) begin
    if (dma_accept) begin
      dma_addr_q  <= bus.dma_addr;
      dma_wdata_q <= bus.dma_wdata;
      dma_we_q    <= bus.dma_we;
    end
  end

  // ---- DMA FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- DMA FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE:  if (dma_accept) state_d = D_PEND;
      D_PEND:  if (dma_go)     state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // ---- DMA FSM: outputs (the done cycle is still blind to dma_ce)
  always_comb begin
    dma_accept = 1'b0;
    dma_go     = 1'b0;
    dma_busy_c = 1'b0;
    case (state_q)
      D_IDLE: dma_accept = bus.dma_ce && !dma_done_p1;
      D_PEND: begin
        dma_go     = !bus.gb_ce;
        dma_busy_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.gb_rdata  = gb_rdata_p1;
  assign bus.dma_rdata = dma_rdata_p1;
  assign bus.dma_done  = dma_done_p1;
  assign bus.dma_busy  = dma_busy_c;
  assign bus.oob_err   = oob_err_q;

endmodule

// File: tb/tb_global_buffer_responder.sv
// Randomized bench for global_buffer_responder with a transaction-level memory model and directed pins.
// Build with GLOBAL_BUFFER_PARITY_EN to also exercise the parity check.
module tb_global_buffer_responder;

  logic clk;
  logic rst;

  global_buffer_responder_if bus();

  global_buffer_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: plain memory array plus the DMA request as a queued transaction
  logic [15:0] mm  [4096];
  bit          bad [4096];
  bit          pend;
  logic [31:0] p_addr;
  logic [15:0] p_wd;
  logic        p_we;
  logic [15:0] exp_gb, exp_dma;
  logic        exp_done, exp_busy, exp_oob, exp_par;
  logic [15:0] pre [64];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0; exp_gb = '0; exp_dma = '0;
    exp_done = 1'b0; exp_busy = 1'b0; exp_oob = 1'b0; exp_par = 1'b0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic we, input logic [15:0] wd,
                              output logic [15:0] rd);
    rd = 16'h0000;
    if (a >= 32'd4096) begin
      exp_oob = 1'b1;
    end else if (we) begin
      mm[a[11:0]]  = wd;
      bad[a[11:0]] = 1'b0;
    end else begin
      rd = mm[a[11:0]];
      if (bad[a[11:0]]) exp_par = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic go, take;
    logic [15:0] rd;
    go   = pend && !bus.gb_ce;
    take = !pend && !exp_done && bus.dma_ce;
    if (bus.gb_ce) begin
      model_access(bus.gb_addr, bus.gb_we, bus.gb_wdata, rd);
      if (!bus.gb_we) exp_gb = rd;
    end
    if (go) begin
      model_access(p_addr, p_we, p_wd, rd);
      if (!p_we) exp_dma = rd;
      pend = 1'b0;
    end
    exp_done = go;
    if (take) begin
      pend = 1'b1; p_addr = bus.dma_addr; p_wd = bus.dma_wdata; p_we = bus.dma_we;
    end
    exp_busy = pend;
  endtask

  // Compare process: every falling edge, DUT against model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("gb_rdata",   {16'h0, bus.gb_rdata},  {16'h0, exp_gb});
      cmp("dma_rdata",  {16'h0, bus.dma_rdata}, {16'h0, exp_dma});
      cmp("dma_done",   {31'h0, bus.dma_done},  {31'h0, exp_done});
      cmp("dma_busy",   {31'h0, bus.dma_busy},  {31'h0, exp_busy});
      cmp("oob_err",    {31'h0, bus.oob_err},   {31'h0, exp_oob});
      cmp("parity_err", {31'h0, bus.parity_err}, {31'h0, exp_par});
    end
  end

  task automatic drive(input bit gce, input bit gwe, input logic [31:0] ga, input logic [15:0] gd,
                       input bit dce, input bit dwe, input logic [31:0] da, input logic [15:0] dd);
    bus.gb_ce = gce;  bus.gb_we = gwe;  bus.gb_addr = ga;  bus.gb_wdata = gd;
    bus.dma_ce = dce; bus.dma_we = dwe; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 16'h0, 0, 0, 32'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(15) == 0) return 32'h0000_1000 | ($urandom & 32'hFFFF_F0FF);
    return 32'($urandom_range(63));
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin mm[i] = '0; bad[i] = 1'b0; end
    p_addr = '0; p_wd = '0; p_we = 1'b0;
    model_reset();
    idle();
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) step();
    cmp("reset gb_rdata", {16'h0, bus.gb_rdata}, 32'h0);
    cmp("reset dma_busy", {31'h0, bus.dma_busy}, 32'h0);
    rst = 1'b0;

    // Preload the region used by the random phase
    for (int i = 0; i < 64; i++) begin
      pre[i] = 16'($urandom);
      drive(1, 1, 32'(i), pre[i], 0, 0, 32'h0, 16'h0);
      step();
    end

    // Reset mid-request drops the DMA write
    drive(1, 0, 32'h0, 16'h0, 1, 1, 32'h5, 16'hDEAD);
    step();
    drive(1, 0, 32'h1, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("pending before reset", {31'h0, bus.dma_busy}, 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    cmp("busy in reset", {31'h0, bus.dma_busy}, 32'h0);
    cmp("gb_rdata in reset", {16'h0, bus.gb_rdata}, 32'h0);
    idle();
    step();
    rst = 1'b0;
    repeat (3) step();
    drive(1, 0, 32'h5, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("dropped write absent", {16'h0, bus.gb_rdata}, {16'h0, pre[5]});

    // Scheduler write then read
    drive(1, 1, 32'h10, 16'hBEEF, 0, 0, 32'h0, 16'h0);
    step();
    drive(1, 0, 32'h10, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("gb read 0x10", {16'h0, bus.gb_rdata}, 32'hBEEF);

    // DMA read with the scheduler idle
    drive(0, 0, 32'h0, 16'h0, 1, 0, 32'h10, 16'h0);
    step();
    cmp("dma busy after N", {31'h0, bus.dma_busy}, 32'h1);
    cmp("dma done after N", {31'h0, bus.dma_done}, 32'h0);
    idle();
    step();
    cmp("dma done after N+1", {31'h0, bus.dma_done}, 32'h1);
    cmp("dma rdata 0x10", {16'h0, bus.dma_rdata}, 32'hBEEF);
    cmp("dma busy after N+1", {31'h0, bus.dma_busy}, 32'h0);
    step();
    cmp("dma done one pulse", {31'h0, bus.dma_done}, 32'h0);

    // Contention: DMA write waits while the scheduler owns the port; extra dma_ce is ignored
    drive(1, 0, 32'h10, 16'h0, 1, 1, 32'h20, 16'h1234);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h11, 16'h0, 1, 1, 32'h30, 16'h7777);
      step();
      cmp("busy under contention", {31'h0, bus.dma_busy}, 32'h1);
    end
    drive(0, 0, 32'h0, 16'h0, 1, 1, 32'h30, 16'h7777);
    step();
    cmp("done after gb_ce drops", {31'h0, bus.dma_done}, 32'h1);
    drive(1, 0, 32'h20, 16'h0, 1, 1, 32'h30, 16'h7777);
    step();
    cmp("gb read 0x20", {16'h0, bus.gb_rdata}, 32'h1234);
    drive(1, 0, 32'h30, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("ignored dma write", {16'h0, bus.gb_rdata}, {16'h0, pre[48]});

    // Out of range accesses
    drive(1, 1, 32'h1000, 16'h5555, 0, 0, 32'h0, 16'h0);
    step();
    cmp("oob_err set", {31'h0, bus.oob_err}, 32'h1);
    drive(1, 0, 32'h0, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("mem[0] unchanged", {16'h0, bus.gb_rdata}, {16'h0, pre[0]});
    drive(1, 0, 32'h1000, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    cmp("oob gb read", {16'h0, bus.gb_rdata}, 32'h0);
    drive(0, 0, 32'h0, 16'h0, 1, 0, 32'h8000_0010, 16'h0);
    step();
    idle();
    step();
    cmp("oob dma done", {31'h0, bus.dma_done}, 32'h1);
    cmp("oob dma rdata", {16'h0, bus.dma_rdata}, 32'h0);

    // Clear sticky flags, then randomized traffic
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(1) == 1, $urandom_range(1) == 1, rand_addr(), 16'($urandom),
            $urandom_range(2) == 0, $urandom_range(1) == 1, rand_addr(), 16'($urandom));
      step();
    end
    idle();
    repeat (2) step();

    // Parity: corrupt one stored bit, then read it back
    drive(1, 1, 32'h10, 16'hBEEF, 0, 0, 32'h0, 16'h0);
    step();
    idle();
`ifdef GLOBAL_BUFFER_PARITY_EN
    dut.mem[16][3] = ~dut.mem[16][3];
    mm[16] = mm[16] ^ 16'h0008;
    bad[16] = 1'b1;
`endif
    step();
    drive(1, 0, 32'h10, 16'h0, 0, 0, 32'h0, 16'h0);
    step();
    idle();
    step();
`ifdef GLOBAL_BUFFER_PARITY_EN
    cmp("parity_err sticky", {31'h0, bus.parity_err}, 32'h1);
`else
    cmp("parity_err tied low", {31'h0, bus.parity_err}, 32'h0);
`endif
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
